// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream_mux_arb block and its benches.
// Mode encodings for the runtime arbitration selector.
package stream_mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr sits at bit 0,
// pick the lowest set bit, then rotate the one-hot pick back.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_id
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   pick_rot;
    logic [2*N-1:0] pick_dbl;
    logic [SW-1:0]  pos;
    logic           found;
    int             id_sum;

    always_comb begin
        req_dbl  = {req, req};
        req_rot  = req_dbl[ptr +: N];
        found    = 1'b0;
        pos      = '0;
        for (int i = 0; i < N; i++) begin
            if (req_rot[i] && !found) begin
                found = 1'b1;
                pos   = i[SW-1:0];
            end
        end
        pick_rot = found ? (N'(1) << pos) : '0;
        // Upper half of the doubled, left-shifted pick is the rotate-back.
        pick_dbl = {pick_rot, pick_rot} << ptr;
        gnt      = pick_dbl[2*N-1:N];
        id_sum   = int'(pos) + int'(ptr);
        if (id_sum >= N) begin
            id_sum = id_sum - N;
        end
        gnt_id   = id_sum[SW-1:0];
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with a single registered output stage and
// either fixed-select or round-robin arbitration chosen at runtime.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST_X,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);

    logic [SW-1:0] rr_ptr;
    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_id;
    logic [N-1:0]  fix_gnt;
    logic [N-1:0]  gnt;
    logic [SW-1:0] gnt_id;
    logic          free;
    logic          xfer;
    logic [W-1:0]  data_p0;
    logic          vld_p1;
    logic [W-1:0]  data_p1;
    logic [SW-1:0] ch_p1;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .gnt    (rr_gnt),
        .gnt_id (rr_id)
    );

    // Stage p0: grant selection and input handshake
    always_comb begin
        fix_gnt = '0;
        if (int'(sel) < N) begin
            fix_gnt[sel] = in_valid[sel];
        end
        gnt    = (mode == MODE_RR) ? rr_gnt : fix_gnt;
        gnt_id = (mode == MODE_RR) ? rr_id  : sel;
        free   = ~vld_p1 | out_ready;
        // Gating with RST_X keeps ready low while reset is held.
        in_ready = gnt & {N{free & RST_X}};
        xfer     = |(in_valid & in_ready);
        data_p0  = in_data[int'(gnt_id) * W +: W];
    end

    // Stage p1: output register
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_p0;
            ch_p1   <= gnt_id;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rr_ptr <= '0;
        end else if (xfer && (mode == MODE_RR)) begin
            rr_ptr <= (gnt_id == SW'(N - 1)) ? '0 : gnt_id + SW'(1);
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;

endmodule
